// File: rtl/lsm_pkg.sv
// Purpose: shared opcode constants and FSM state type for the LM/SM sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lsm_pkg;

    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } state_t;

    function automatic logic is_lsm(input logic [3:0] op);
        return (op == OP_LM) || (op == OP_SM);
    endfunction

endpackage

// File: rtl/lsb_enc.sv
// Purpose: lowest-set-bit encoder; gives the index, a found flag and a one-hot clear mask.
// Latency: combinational.
// Backpressure: none.
// Ports: vec (input bit vector), index (position of lowest set bit), found (vec != 0),
//        clr (one-hot mask of that bit, all zero when nothing found).
module lsb_enc #(
    parameter int W  = 8,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] index,
    output logic          found,
    output logic [W-1:0]  clr
);

    // Scan from the top down so the last hit written is the lowest bit.
    always_comb begin
        index = '0;
        found = 1'b0;
        clr   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index  = IW'(i);
                found  = 1'b1;
                clr    = '0;
                clr[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lsm_sequencer.sv
// Purpose: expands LM/SM into one register-transfer micro-op per list bit (lowest first); other instructions pass through.
// Latency: one cycle from acceptance to first micro-op; a k-bit list issues over k consecutive cycles.
// Backpressure: output register advances only when empty or out_ready; in_ready drops while a list is being walked.
// Ports: clk/reset_n; in_valid/in_ir/in_pc/in_ready from pipe1; flush cancels; out_valid/out_ready plus
//        registered micro-op fields (ir, pc, lsm, load, store, base, reg, offset, first, last, r7_wr) to decode.
module lsm_sequencer
    import lsm_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int REG_AW = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_ir,
    input  logic [DATA_W-1:0] in_pc,
    output logic              in_ready,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_ir,
    output logic [DATA_W-1:0] out_pc,
    output logic              out_lsm,
    output logic              out_load,
    output logic              out_store,
    output logic [2:0]        out_base,
    output logic [REG_AW-1:0] out_reg,
    output logic [REG_AW-1:0] out_offset,
    output logic              out_first,
    output logic              out_last,
    output logic              out_r7_wr
);

    typedef struct packed {
        logic [DATA_W-1:0] ir;
        logic [DATA_W-1:0] pc;
        logic              lsm;
        logic              load;
        logic              store;
        logic [2:0]        base;
        logic [REG_AW-1:0] rg;
        logic [REG_AW-1:0] offset;
        logic              first;
        logic              last;
        logic              r7_wr;
    } uop_t;

    state_t            state_q, state_d;
    logic [NREG-1:0]   pend_q, pend_d;
    logic              vld_q, vld_d;
    uop_t              uop_q, uop_d;

    logic              adv;
    logic [3:0]        in_op;
    logic [NREG-1:0]   enc_vec;
    logic [REG_AW-1:0] enc_idx;
    logic              enc_found;
    logic [NREG-1:0]   enc_clr;
    logic [NREG-1:0]   rem;

    assign adv   = !vld_q || out_ready;
    assign in_op = in_ir[DATA_W-1 -: 4];
    // reset_n gating keeps pipe1 stalled while the block is held in reset.
    assign in_ready = reset_n && (state_q == IDLE) && adv && !flush;

    // One encoder serves both the first issue (fresh list) and the SEQ walk (pending mask).
    assign enc_vec = (state_q == IDLE) ? in_ir[NREG-1:0] : pend_q;

    lsb_enc #(
        .W  (NREG),
        .IW (REG_AW)
    ) u_lsb_enc (
        .vec   (enc_vec),
        .index (enc_idx),
        .found (enc_found),
        .clr   (enc_clr)
    );

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        vld_d   = vld_q;
        uop_d   = uop_q;
        rem     = enc_vec & ~enc_clr;

        if (flush) begin
            state_d = IDLE;
            pend_d  = '0;
            vld_d   = 1'b0;
            uop_d   = '0;
        end else if (adv) begin
            if (state_q == IDLE) begin
                vld_d = 1'b0;
                uop_d = '0;
                if (in_valid) begin
                    if (!is_lsm(in_op)) begin
                        vld_d       = 1'b1;
                        uop_d.ir    = in_ir;
                        uop_d.pc    = in_pc;
                        uop_d.first = 1'b1;
                        uop_d.last  = 1'b1;
                    end else if (enc_found) begin
                        vld_d        = 1'b1;
                        uop_d.ir     = in_ir;
                        uop_d.pc     = in_pc;
                        uop_d.lsm    = 1'b1;
                        uop_d.load   = (in_op == OP_LM);
                        uop_d.store  = (in_op == OP_SM);
                        uop_d.base   = in_ir[11:9];
                        uop_d.rg     = enc_idx;
                        uop_d.offset = '0;
                        uop_d.first  = 1'b1;
                        uop_d.last   = (rem == '0);
                        uop_d.r7_wr  = (in_op == OP_LM) && (enc_idx == REG_AW'(NREG - 1));
                        pend_d       = rem;
                        state_d      = (rem == '0) ? IDLE : SEQ;
                    end
                    // An empty list retires silently as a NOP: nothing is emitted.
                end
            end else begin
                // ir/pc/base/load/store carry over from the previous micro-op.
                vld_d        = 1'b1;
                uop_d.rg     = enc_idx;
                uop_d.offset = uop_q.offset + REG_AW'(1);
                uop_d.first  = 1'b0;
                uop_d.last   = (rem == '0);
                uop_d.r7_wr  = uop_q.load && (enc_idx == REG_AW'(NREG - 1));
                pend_d       = rem;
                if (rem == '0) begin
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            vld_q   <= 1'b0;
            uop_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            vld_q   <= vld_d;
            uop_q   <= uop_d;
        end
    end

    assign out_valid  = vld_q;
    assign out_ir     = uop_q.ir;
    assign out_pc     = uop_q.pc;
    assign out_lsm    = uop_q.lsm;
    assign out_load   = uop_q.load;
    assign out_store  = uop_q.store;
    assign out_base   = uop_q.base;
    assign out_reg    = uop_q.rg;
    assign out_offset = uop_q.offset;
    assign out_first  = uop_q.first;
    assign out_last   = uop_q.last;
    assign out_r7_wr  = uop_q.r7_wr;

endmodule

// File: tb/tb_lsm_sequencer.sv
// Purpose: directed bench for lsm_sequencer with a queue scoreboard of expected micro-ops.
// Latency: n/a.
// Backpressure: out_ready is driven per step to exercise hold behaviour.
module tb_lsm_sequencer;
    import lsm_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [15:0] in_ir;
    logic [15:0] in_pc;
    logic        in_ready;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_ir;
    logic [15:0] out_pc;
    logic        out_lsm;
    logic        out_load;
    logic        out_store;
    logic [2:0]  out_base;
    logic [2:0]  out_reg;
    logic [2:0]  out_offset;
    logic        out_first;
    logic        out_last;
    logic        out_r7_wr;

    lsm_sequencer #(
        .DATA_W (16),
        .NREG   (8),
        .REG_AW (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ir      (in_ir),
        .in_pc      (in_pc),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_ir     (out_ir),
        .out_pc     (out_pc),
        .out_lsm    (out_lsm),
        .out_load   (out_load),
        .out_store  (out_store),
        .out_base   (out_base),
        .out_reg    (out_reg),
        .out_offset (out_offset),
        .out_first  (out_first),
        .out_last   (out_last),
        .out_r7_wr  (out_r7_wr)
    );

    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] pc;
        logic        lsm;
        logic        load;
        logic        store;
        logic [2:0]  base;
        logic [2:0]  rg;
        logic [2:0]  off;
        logic        first;
        logic        last;
        logic        r7;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t observed();
        exp_t o;
        o.ir    = out_ir;
        o.pc    = out_pc;
        o.lsm   = out_lsm;
        o.load  = out_load;
        o.store = out_store;
        o.base  = out_base;
        o.rg    = out_reg;
        o.off   = out_offset;
        o.first = out_first;
        o.last  = out_last;
        o.r7    = out_r7_wr;
        return o;
    endfunction

    function automatic logic [63:0] all_outs();
        return {15'd0, out_valid, out_ir, out_pc, out_lsm, out_load, out_store, out_base,
                out_reg, out_offset, out_first, out_last, out_r7_wr};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference expansion of one accepted instruction into its micro-op list.
    task automatic push_instr(input logic [15:0] ir, input logic [15:0] pc);
        logic [3:0] op;
        logic [7:0] list;
        int         cnt;
        int         k;
        exp_t       e;
        op   = ir[15:12];
        list = ir[7:0];
        if (op == OP_LM || op == OP_SM) begin
            cnt = 0;
            for (int i = 0; i < 8; i++) if (list[i]) cnt++;
            k = 0;
            for (int i = 0; i < 8; i++) begin
                if (list[i]) begin
                    e       = '0;
                    e.ir    = ir;
                    e.pc    = pc;
                    e.lsm   = 1'b1;
                    e.load  = (op == OP_LM);
                    e.store = (op == OP_SM);
                    e.base  = ir[11:9];
                    e.rg    = 3'(i);
                    e.off   = 3'(k);
                    e.first = (k == 0);
                    e.last  = (k == cnt - 1);
                    e.r7    = (op == OP_LM) && (i == 7);
                    sb_q.push_back(e);
                    k++;
                end
            end
        end else begin
            e       = '0;
            e.ir    = ir;
            e.pc    = pc;
            e.first = 1'b1;
            e.last  = 1'b1;
            sb_q.push_back(e);
        end
    endtask

    task automatic sb_check();
        exp_t e;
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_uop", 64'(observed()), 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_uop", 64'(observed()), 64'(e));
            end
        end
    endtask

    // One cycle: drive inputs at the falling edge, let them settle, score any handshake.
    task automatic cyc(input logic v, input logic [15:0] ir, input logic [15:0] pc,
                       input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = v;
        in_ir     = ir;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        #1;
        sb_check();
    endtask

    initial begin
        logic [2:0] regs_a5 [4];
        regs_a5 = '{3'd0, 3'd2, 3'd5, 3'd7};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_ir     = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_outputs", all_outs(), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        reset_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Pass-through ADD
        cyc(1'b1, 16'h0A58, 16'h0010, 1'b1, 1'b0);
        chk("add_in_ready", 64'(in_ready), 64'd1);
        push_instr(16'h0A58, 16'h0010);
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("add_out_valid", 64'(out_valid), 64'd1);
        chk("add_fields", {out_lsm, out_ir, out_pc, out_first, out_last},
            {1'b0, 16'h0A58, 16'h0010, 1'b1, 1'b1});

        // LM R2, list 0xA5, then back-to-back SM with ignored bit 8 set
        cyc(1'b1, 16'h64A5, 16'h0020, 1'b1, 1'b0);
        chk("lm_a5_accept", 64'(in_ready), 64'd1);
        push_instr(16'h64A5, 16'h0020);
        for (int c = 1; c <= 4; c++) begin
            if (c < 4) cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
            else       cyc(1'b1, 16'h7101, 16'h0030, 1'b1, 1'b0);
            chk("lm_a5_reg", 64'(out_reg), 64'(regs_a5[c-1]));
            chk("lm_a5_offset", 64'(out_offset), 64'(c - 1));
            chk("lm_a5_first_last", {out_first, out_last}, {c == 1, c == 4});
            chk("lm_a5_in_ready", 64'(in_ready), 64'(c == 4));
        end
        push_instr(16'h7101, 16'h0030);
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("sm_b2b_single", {out_valid, out_lsm, out_store, out_reg, out_first, out_last},
            {1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1});

        // SM list 0x0E with out_ready low: reg2 held, then reg3
        cyc(1'b1, 16'h720E, 16'h0040, 1'b1, 1'b0);
        push_instr(16'h720E, 16'h0040);
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("sm_c1_reg", {out_reg, out_offset}, {3'd1, 3'd0});
        for (int c = 2; c <= 4; c++) begin
            cyc(1'b0, 16'h0, 16'h0, (c == 4), 1'b0);
            chk("sm_hold_reg", {out_valid, out_reg, out_offset, out_first, out_last},
                {1'b1, 3'd2, 3'd1, 1'b0, 1'b0});
            chk("sm_hold_in_ready", 64'(in_ready), 64'd0);
        end
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("sm_c5_reg", {out_reg, out_offset, out_last, out_base}, {3'd3, 3'd2, 1'b1, 3'd1});
        chk("sm_c5_in_ready", 64'(in_ready), 64'd1);

        // LM with empty list retires as NOP; ADD follows immediately
        cyc(1'b1, 16'h6000, 16'h0050, 1'b1, 1'b0);
        cyc(1'b1, 16'h0A58, 16'h0060, 1'b1, 1'b0);
        chk("empty_out_valid", 64'(out_valid), 64'd0);
        chk("empty_in_ready", 64'(in_ready), 64'd1);
        push_instr(16'h0A58, 16'h0060);
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("empty_next_add", {out_valid, out_pc}, {1'b1, 16'h0060});

        // LM list 0x0F flushed at cycle 2
        cyc(1'b1, 16'h600F, 16'h0070, 1'b1, 1'b0);
        push_instr(16'h600F, 16'h0070);
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        cyc(1'b1, 16'h0A58, 16'h0077, 1'b1, 1'b1);
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        sb_q.delete();
        cyc(1'b1, 16'h0A58, 16'h0080, 1'b1, 1'b0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_reaccept", 64'(in_ready), 64'd1);
        push_instr(16'h0A58, 16'h0080);
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("flush_next_add", {out_valid, out_lsm, out_pc}, {1'b1, 1'b0, 16'h0080});
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("flush_no_leftover", 64'(out_valid), 64'd0);

        // LM list 0x80: single micro-op writing R7
        cyc(1'b1, 16'h6680, 16'h0090, 1'b1, 1'b0);
        push_instr(16'h6680, 16'h0090);
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("r7_fields", {out_valid, out_load, out_reg, out_r7_wr, out_first, out_last, out_base},
            {1'b1, 1'b1, 3'd7, 1'b1, 1'b1, 1'b1, 3'd3});
        chk("r7_in_ready", 64'(in_ready), 64'd1);

        // Asynchronous reset mid-sequence of list 0xFF
        cyc(1'b1, 16'h66FF, 16'h00A0, 1'b1, 1'b0);
        push_instr(16'h66FF, 16'h00A0);
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_outputs", all_outs(), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd0);
        sb_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("rst_no_resume", 64'(out_valid), 64'd0);

        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
